// File: rtl/rs_alloc_select_if.sv
// Dispatch/wakeup/select handshake bundle for one reservation-station bank.
// The master side is the pipe front-end; the slave side is the RS controller.
interface rs_alloc_select_if #(
  parameter int unsigned RS_ENTRIES = 8,
  parameter int unsigned IDX_W      = $clog2(RS_ENTRIES)
);
  logic                  dispatch_valid;
  logic                  entry_free;
  logic [IDX_W-1:0]      entry_index;
  logic [RS_ENTRIES-1:0] ready_vec;
  logic                  issue_valid;
  logic [IDX_W-1:0]      issue_index;
  logic                  issue_en;
  logic                  flush;
  logic [IDX_W:0]        occupancy;

  modport master (
    output dispatch_valid, ready_vec, issue_en, flush,
    input  entry_free, entry_index, issue_valid, issue_index, occupancy
  );

  modport slave (
    input  dispatch_valid, ready_vec, issue_en, flush,
    output entry_free, entry_index, issue_valid, issue_index, occupancy
  );
endinterface

// File: rtl/rs_alloc_select_ctrl.sv
// Reservation-station bank controller: valid bitmap, age matrix, lowest-free
// allocation and oldest-ready selection for one execution pipe.
module rs_alloc_select_ctrl #(
  parameter int unsigned RS_ENTRIES = 8
) (
  input logic              clk,
  input logic              rst,
  rs_alloc_select_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(RS_ENTRIES);

  logic [RS_ENTRIES-1:0] valid_q, valid_d;
  // older_q[i][j] = 1 means entry i was allocated before entry j
  logic [RS_ENTRIES-1:0] older_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] older_d [RS_ENTRIES];
  logic [IDX_W:0]        occ_q, occ_d;

  logic                  entry_free;
  logic [IDX_W-1:0]      entry_index;
  logic                  alloc_found;
  logic [RS_ENTRIES-1:0] eligible;
  logic                  issue_valid;
  logic [IDX_W-1:0]      issue_index;
  logic                  blocked;
  logic                  do_alloc;
  logic                  do_free;

  // Allocation: lowest-numbered free entry, 0 when full.
  always_comb begin
    entry_free  = |(~valid_q);
    entry_index = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < int'(RS_ENTRIES); i++) begin
      if (!valid_q[i] && !alloc_found) begin
        entry_index = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  // Select: the eligible entry that no other eligible entry is older than.
  always_comb begin
    eligible    = valid_q & bus.ready_vec;
    issue_valid = |eligible;
    issue_index = '0;
    blocked     = 1'b0;
    for (int k = RS_ENTRIES - 1; k >= 0; k--) begin
      blocked = 1'b0;
      for (int j = 0; j < int'(RS_ENTRIES); j++) begin
        if (eligible[j] && older_q[j][k]) begin
          blocked = 1'b1;
        end
      end
      if (eligible[k] && !blocked) begin
        issue_index = IDX_W'(k);
      end
    end
  end

  always_comb begin
    // Illegal dispatch into a full bank is dropped here.
    do_alloc = bus.dispatch_valid & entry_free;
    do_free  = issue_valid & bus.issue_en;
    valid_d  = valid_q;
    occ_d    = occ_q;
    for (int i = 0; i < int'(RS_ENTRIES); i++) begin
      older_d[i] = older_q[i];
    end
    if (bus.flush) begin
      valid_d = '0;
      occ_d   = '0;
    end else begin
      if (do_free) begin
        valid_d[issue_index] = 1'b0;
      end
      if (do_alloc) begin
        valid_d[entry_index] = 1'b1;
        older_d[entry_index] = '0;
        for (int j = 0; j < int'(RS_ENTRIES); j++) begin
          older_d[j][entry_index] = valid_q[j];
        end
      end
      occ_d = occ_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_free);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < int'(RS_ENTRIES); i++) begin
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < int'(RS_ENTRIES); i++) begin
        older_q[i] <= older_d[i];
      end
    end
  end

  assign bus.entry_free  = entry_free;
  assign bus.entry_index = entry_index;
  assign bus.issue_valid = issue_valid;
  assign bus.issue_index = issue_index;
  assign bus.occupancy   = occ_q;

endmodule

// File: tb/tb_rs_alloc_select_ctrl.sv
// Directed bench for rs_alloc_select_ctrl: vector table for fill/drain/age
// order plus hand-written stall, full-bank, flush and reset sequences.
module tb_rs_alloc_select_ctrl;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   illegal_cnt = 0;

  always #5 clk = ~clk;

  rs_alloc_select_if #(.RS_ENTRIES(N)) bus ();

  rs_alloc_select_ctrl #(.RS_ENTRIES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Dispatch into a full bank is a protocol violation; record it.
  always @(posedge clk) begin
    if (!rst && bus.dispatch_valid && !bus.entry_free) begin
      illegal_cnt++;
      $display("assertion: dispatch_valid while entry_free=0 at %0t", $time);
    end
  end

  typedef struct {
    logic       d;
    logic [7:0] r;
    logic       ie;
    logic       fl;
    logic       ef;
    logic [2:0] ei;
    logic       iv;
    logic [2:0] ii;
    logic [3:0] occ;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic d, input logic [7:0] r, input logic ie,
                              input logic fl, input logic ef, input logic [2:0] ei,
                              input logic iv, input logic [2:0] ii, input logic [3:0] occ);
    vec_t v;
    v.d = d; v.r = r; v.ie = ie; v.fl = fl;
    v.ef = ef; v.ei = ei; v.iv = iv; v.ii = ii; v.occ = occ;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Apply inputs, check outputs mid-cycle, then advance past the next edge.
  task automatic cyc(input string tag, input logic d, input logic [7:0] r, input logic ie,
                     input logic fl, input logic ef, input logic [2:0] ei,
                     input logic iv, input logic [2:0] ii, input logic [3:0] occ);
    bus.dispatch_valid = d;
    bus.ready_vec      = r;
    bus.issue_en       = ie;
    bus.flush          = fl;
    #2;
    chk({tag, ".entry_free"},  int'(bus.entry_free),  int'(ef));
    chk({tag, ".entry_index"}, int'(bus.entry_index), int'(ei));
    chk({tag, ".issue_valid"}, int'(bus.issue_valid), int'(iv));
    chk({tag, ".issue_index"}, int'(bus.issue_index), int'(ii));
    chk({tag, ".occupancy"},   int'(bus.occupancy),   int'(occ));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.dispatch_valid = 1'b0;
    bus.ready_vec      = '0;
    bus.issue_en       = 1'b0;
    bus.flush          = 1'b0;

    // Test 1: fill 8 entries, nothing ready.
    for (int i = 0; i < 8; i++) add(1, 8'h00, 0, 0, 1, 3'(i), 0, 0, 4'(i));
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8);
    // Test 2: drain in allocation order.
    for (int i = 0; i < 8; i++) add(0, 8'hFF, 1, 0, (i != 0), 0, 1, 3'(i), 4'(8 - i));
    add(0, 8'hFF, 0, 0, 1, 0, 0, 0, 0);
    // Test 3: re-allocated entry 0 becomes youngest.
    for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 1, 3'(i), 0, 0, 4'(i));
    add(0, 8'h01, 1, 0, 1, 3, 1, 0, 3);
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 2);
    add(0, 8'h07, 1, 0, 1, 3, 1, 1, 3);
    add(0, 8'h07, 1, 0, 1, 1, 1, 2, 2);
    add(0, 8'h07, 1, 0, 1, 1, 1, 0, 1);
    add(0, 8'h07, 0, 0, 1, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    chk("reset.entry_free",  int'(bus.entry_free),  1);
    chk("reset.entry_index", int'(bus.entry_index), 0);
    chk("reset.issue_valid", int'(bus.issue_valid), 0);
    chk("reset.issue_index", int'(bus.issue_index), 0);
    chk("reset.occupancy",   int'(bus.occupancy),   0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      cyc($sformatf("vec%0d", i), tbl[i].d, tbl[i].r, tbl[i].ie, tbl[i].fl,
          tbl[i].ef, tbl[i].ei, tbl[i].iv, tbl[i].ii, tbl[i].occ);
    end

    // Test 4: stall holds younger pick; an older ready entry displaces it.
    for (int i = 0; i < 4; i++) cyc("t4.fill", 1, 8'h00, 0, 0, 1, 3'(i), 0, 0, 4'(i));
    cyc("t4.free1", 0, 8'h06, 1, 0, 1, 4, 1, 1, 4);
    cyc("t4.free2", 0, 8'h06, 1, 0, 1, 1, 1, 2, 3);
    for (int i = 0; i < 3; i++) cyc("t4.stall", 0, 8'h08, 0, 0, 1, 1, 1, 3, 2);
    cyc("t4.displace", 0, 8'h09, 0, 0, 1, 1, 1, 0, 2);
    cyc("t4.issue0",   0, 8'h09, 1, 0, 1, 1, 1, 0, 2);
    cyc("t4.issue3",   0, 8'h09, 1, 0, 1, 0, 1, 3, 1);
    cyc("t4.empty",    0, 8'h09, 0, 0, 1, 0, 0, 0, 0);

    // Test 5: full bank, issue plus illegal dispatch in the same cycle.
    for (int i = 0; i < 8; i++) cyc("t5.fill", 1, 8'h00, 0, 0, 1, 3'(i), 0, 0, 4'(i));
    cyc("t5.collide", 1, 8'hFF, 1, 0, 0, 0, 1, 0, 8);
    cyc("t5.after",   0, 8'h00, 0, 0, 1, 0, 0, 0, 7);
    chk("t5.illegal_flagged", illegal_cnt, 1);
    cyc("t5.flush",   0, 8'h00, 0, 1, 1, 0, 0, 0, 7);
    cyc("t5.flushed", 0, 8'hFF, 0, 0, 1, 0, 0, 0, 0);

    // Test 6: flush beats simultaneous dispatch and issue.
    for (int i = 0; i < 5; i++) cyc("t6.fill", 1, 8'h00, 0, 0, 1, 3'(i), 0, 0, 4'(i));
    cyc("t6.flush", 1, 8'hFF, 1, 1, 1, 5, 1, 0, 5);
    cyc("t6.after", 0, 8'hFF, 0, 0, 1, 0, 0, 0, 0);

    // Mid-operation reset returns outputs to reset values.
    cyc("rst.fill", 1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    cyc("rst.fill", 1, 8'h00, 0, 0, 1, 1, 0, 0, 1);
    rst = 1'b1;
    cyc("rst.edge", 0, 8'hFF, 0, 0, 1, 2, 1, 0, 2);
    rst = 1'b0;
    cyc("rst.after", 0, 8'hFF, 0, 0, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach summary, expected completion");
    $fatal(1);
  end

endmodule
